// File: rtl/yari_decode_pkg.sv
// Shared decode-stage definitions: destination/operand specifier helpers,
// producer latency classes and a constant-safe clog2.
package yari_decode_pkg;

    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Specifiers are {used, index}; callers zero-extend to 32 bits.
    function automatic logic wbr_used(input logic [31:0] wbr, input int unsigned rb);
        return ((wbr >> rb) & 32'd1) != 32'd0;
    endfunction

    // A real write needs the valid bit and a nonzero index; r0 is never written.
    function automatic logic wbr_writes(input logic [31:0] wbr, input int unsigned rb);
        return wbr_used(wbr, rb) && ((wbr & ((32'd1 << rb) - 32'd1)) != 32'd0);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file built from two identical RAM copies with
// synchronous reads; a read during a write to the same entry returns the old value.
module regfile_2r1w #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic            clock,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr_a,
    input  logic [AW-1:0]   i_raddr_b,
    output logic [XLEN-1:0] o_rdata_a,
    output logic [XLEN-1:0] o_rdata_b
);

    logic [XLEN-1:0] r_mem_a [NREGS];
    logic [XLEN-1:0] r_mem_b [NREGS];
    logic [XLEN-1:0] r_rdata_a;
    logic [XLEN-1:0] r_rdata_b;

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem_a[i_waddr] <= i_wdata;
            r_mem_b[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_a <= r_mem_a[i_raddr_a];
            r_rdata_b <= r_mem_b[i_raddr_b];
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/stage_d_scoreboard.sv
// Decode/operand-read stage: regfile, x/m/w/w2 bypass and per-register latency scoreboard.
// Define SCOREBOARD_PERF_EN to add the perf_stall_cycles / perf_issued counters.
module stage_d_scoreboard
    import yari_decode_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned MAX_LAT = 3,
    localparam int unsigned RB     = clog2(NREGS),
    localparam int unsigned CB     = clog2(MAX_LAT + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [RB:0]     i_rs,
    input  logic [RB:0]     i_rt,
    input  logic [RB:0]     i_wbr,
    input  logic [CB-1:0]   i_lat,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_op2_is_imm,
    input  logic            flush_D,
    input  logic            x_valid,
    input  logic [RB:0]     x_wbr,
    input  logic [XLEN-1:0] x_res,
    input  logic            m_valid,
    input  logic [RB:0]     m_wbr,
    input  logic [XLEN-1:0] m_res,
    input  logic            w_valid,
    input  logic [RB:0]     w_wbr,
    input  logic [XLEN-1:0] w_res,
    output logic            d_valid,
    output logic [RB:0]     d_wbr,
    output logic [XLEN-1:0] d_op1_val,
    output logic [XLEN-1:0] d_rt_val,
    output logic [XLEN-1:0] d_op2_val,
    output logic            d_stall
`ifdef SCOREBOARD_PERF_EN
   ,output logic [31:0]     perf_stall_cycles,
    output logic [47:0]     perf_issued
`endif
);

    logic [CB-1:0]   r_busy [NREGS];
    logic            r_d_valid;
    logic [RB:0]     r_d_wbr;
    logic            r_d_stall;
    logic [RB:0]     r_d_rs;
    logic [RB:0]     r_d_rt;
    logic [XLEN-1:0] r_d_imm;
    logic            r_d_op2_is_imm;
    logic            r_w2_valid;
    logic [RB:0]     r_w2_wbr;
    logic [XLEN-1:0] r_w2_res;

    logic            w_rs_busy;
    logic            w_rt_busy;
    logic            w_waw;
    logic            w_lat_illegal;
    logic            w_stall;
    logic            w_accept;
    logic            w_set_busy;
    logic            w_wr_en;
    logic [XLEN-1:0] w_rf_a;
    logic [XLEN-1:0] w_rf_b;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_rt;

    assign w_rs_busy  = wbr_used(32'(i_rs), RB) && (r_busy[i_rs[RB-1:0]] != '0);
    assign w_rt_busy  = wbr_used(32'(i_rt), RB) && (r_busy[i_rt[RB-1:0]] != '0);
    assign w_set_busy = wbr_writes(32'(i_wbr), RB);
    // A newer writer must not retire before an older one to the same register.
    assign w_waw      = w_set_busy && (r_busy[i_wbr[RB-1:0]] > i_lat);

    generate
        if (((1 << CB) - 1) > MAX_LAT) begin : g_lat_chk
            assign w_lat_illegal = i_lat > CB'(MAX_LAT);
        end else begin : g_lat_ok
            assign w_lat_illegal = 1'b0;
        end
    endgenerate

    assign w_stall  = w_rs_busy | w_rt_busy | w_waw | w_lat_illegal;
    assign i_ready  = ~(i_valid & w_stall);
    assign w_accept = i_valid & ~w_stall;
    assign w_wr_en  = w_valid && wbr_writes(32'(w_wbr), RB);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_busy[r] <= '0;
            end
        end else begin
            r_busy[0] <= '0;
            for (int r = 1; r < NREGS; r++) begin
                if (w_accept && w_set_busy && (i_wbr[RB-1:0] == RB'(r))) begin
                    r_busy[r] <= i_lat;
                end else if (r_busy[r] != '0) begin
                    r_busy[r] <= r_busy[r] - CB'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_d_valid  <= 1'b0;
            r_d_wbr    <= '0;
            r_d_stall  <= 1'b0;
            r_w2_valid <= 1'b0;
        end else begin
            r_d_valid  <= w_accept & ~flush_D;
            r_d_wbr    <= (w_accept && !flush_D) ? i_wbr : '0;
            r_d_stall  <= i_valid & ~i_ready;
            r_w2_valid <= w_wr_en;
        end
    end

    // Operand specifiers travel with the RAM read so bypass compares line up.
    always_ff @(posedge clock) begin
        r_w2_wbr <= w_wbr;
        r_w2_res <= w_res;
        if (w_accept) begin
            r_d_rs         <= i_rs;
            r_d_rt         <= i_rt;
            r_d_imm        <= i_imm;
            r_d_op2_is_imm <= i_op2_is_imm;
        end
    end

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (RB)
    ) u_regfile (
        .clock     (clock),
        .i_we      (w_wr_en),
        .i_waddr   (w_wbr[RB-1:0]),
        .i_wdata   (w_res),
        .i_re      (w_accept),
        .i_raddr_a (i_rs[RB-1:0]),
        .i_raddr_b (i_rt[RB-1:0]),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

    function automatic logic hit(input logic v, input logic [RB:0] wbr, input logic [RB:0] dreg);
        return v && wbr[RB] && (wbr == dreg);
    endfunction

    always_comb begin
        w_op1 = w_rf_a;
        if (r_d_rs[RB-1:0] == '0) begin
            w_op1 = '0;
        end else if (hit(x_valid, x_wbr, r_d_rs)) begin
            w_op1 = x_res;
        end else if (hit(m_valid, m_wbr, r_d_rs)) begin
            w_op1 = m_res;
        end else if (hit(w_valid, w_wbr, r_d_rs)) begin
            w_op1 = w_res;
        end else if (hit(r_w2_valid, r_w2_wbr, r_d_rs)) begin
            w_op1 = r_w2_res;
        end
    end

    always_comb begin
        w_rt = w_rf_b;
        if (r_d_rt[RB-1:0] == '0) begin
            w_rt = '0;
        end else if (hit(x_valid, x_wbr, r_d_rt)) begin
            w_rt = x_res;
        end else if (hit(m_valid, m_wbr, r_d_rt)) begin
            w_rt = m_res;
        end else if (hit(w_valid, w_wbr, r_d_rt)) begin
            w_rt = w_res;
        end else if (hit(r_w2_valid, r_w2_wbr, r_d_rt)) begin
            w_rt = r_w2_res;
        end
    end

    assign d_valid   = r_d_valid;
    assign d_wbr     = r_d_wbr;
    assign d_stall   = r_d_stall;
    assign d_op1_val = w_op1;
    assign d_rt_val  = w_rt;
    assign d_op2_val = r_d_op2_is_imm ? r_d_imm : w_rt;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [47:0] r_perf_issued;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_stall  <= '0;
            r_perf_issued <= '0;
        end else begin
            if (i_valid && !i_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_accept) begin
                r_perf_issued <= r_perf_issued + 48'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_issued       = r_perf_issued;
`endif

endmodule

// File: tb/tb_stage_d_scoreboard.sv
// Scoreboard bench for stage_d_scoreboard: expected D-stage results are queued at issue
// and compared by a negedge monitor whenever d_valid is seen.
module tb_stage_d_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [5:0]  i_rs = '0;
    logic [5:0]  i_rt = '0;
    logic [5:0]  i_wbr = '0;
    logic [1:0]  i_lat = '0;
    logic [31:0] i_imm = '0;
    logic        i_op2_is_imm = 1'b0;
    logic        flush_D = 1'b0;
    logic        x_valid = 1'b0;
    logic [5:0]  x_wbr = '0;
    logic [31:0] x_res = '0;
    logic        m_valid = 1'b0;
    logic [5:0]  m_wbr = '0;
    logic [31:0] m_res = '0;
    logic        w_valid = 1'b0;
    logic [5:0]  w_wbr = '0;
    logic [31:0] w_res = '0;
    logic        d_valid;
    logic [5:0]  d_wbr;
    logic [31:0] d_op1_val;
    logic [31:0] d_rt_val;
    logic [31:0] d_op2_val;
    logic        d_stall;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [47:0] perf_issued;
`endif

    typedef struct {
        logic [5:0]  wbr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        imm;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rf[16];

    always #5 clock = ~clock;

    stage_d_scoreboard u_dut (
        .clock        (clock),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .i_rs         (i_rs),
        .i_rt         (i_rt),
        .i_wbr        (i_wbr),
        .i_lat        (i_lat),
        .i_imm        (i_imm),
        .i_op2_is_imm (i_op2_is_imm),
        .flush_D      (flush_D),
        .x_valid      (x_valid),
        .x_wbr        (x_wbr),
        .x_res        (x_res),
        .m_valid      (m_valid),
        .m_wbr        (m_wbr),
        .m_res        (m_res),
        .w_valid      (w_valid),
        .w_wbr        (w_wbr),
        .w_res        (w_res),
        .d_valid      (d_valid),
        .d_wbr        (d_wbr),
        .d_op1_val    (d_op1_val),
        .d_rt_val     (d_rt_val),
        .d_op2_val    (d_op2_val),
        .d_stall      (d_stall)
`ifdef SCOREBOARD_PERF_EN
       ,.perf_stall_cycles (perf_stall_cycles),
        .perf_issued       (perf_issued)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [5:0] rg(input int n);
        return {1'b1, 5'(n)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_byp();
        x_valid = 1'b0;
        m_valid = 1'b0;
        w_valid = 1'b0;
    endtask

    // Present one instruction, wait (bounded) for acceptance, return in its D cycle.
    task automatic issue(input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] wbr,
                         input logic [1:0] lat, input logic [31:0] imm, input logic op2imm,
                         input logic [31:0] e1, input logic [31:0] e2, input bit push,
                         output int stalls);
        exp_t e;
        stalls       = 0;
        i_valid      = 1'b1;
        i_rs         = rs;
        i_rt         = rt;
        i_wbr        = wbr;
        i_lat        = lat;
        i_imm        = imm;
        i_op2_is_imm = op2imm;
        #1;
        while (!i_ready && stalls < 16) begin
            tick();
            stalls++;
            check_eq("bubble_d_valid", 64'(d_valid), 64'd0);
            check_eq("d_stall", 64'(d_stall), 64'd1);
        end
        if (!i_ready) check_eq("ready_timeout", 64'(i_ready), 64'd1);
        if (push) begin
            e.wbr = flush_D ? 6'd0 : wbr;
            e.op1 = e1;
            e.op2 = e2;
            e.imm = op2imm;
            exp_q.push_back(e);
        end
        tick();
        i_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (d_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_d_valid", 64'(d_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("d_wbr", 64'(d_wbr), 64'(e.wbr));
                    check_eq("d_op1_val", 64'(d_op1_val), 64'(e.op1));
                    check_eq("d_op2_val", 64'(d_op2_val), 64'(e.op2));
                    if (!e.imm) check_eq("d_rt_val", 64'(d_rt_val), 64'(e.op2));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
`ifdef SCOREBOARD_PERF_EN
        logic [31:0] ps0;
        logic [47:0] pi0;
`endif
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_d_valid", 64'(d_valid), 64'd0);
        check_eq("rst_d_stall", 64'(d_stall), 64'd0);
        check_eq("rst_d_wbr", 64'(d_wbr), 64'd0);
        check_eq("rst_ready_idle", 64'(i_ready), 64'd1);
        i_valid = 1'b1;
        i_rs    = rg(1);
        #1;
        check_eq("rst_ready_busy0", 64'(i_ready), 64'd1);
        i_valid = 1'b0;

        for (int i = 1; i < 16; i++) begin
            rf[i]   = 32'h1000_0000 + 32'(i);
            w_valid = 1'b1;
            w_wbr   = rg(i);
            w_res   = rf[i];
            tick();
        end
        clr_byp();
        tick();

        // lat=0 producer, back-to-back consumer picks result from x_
        issue(rg(1), rg(2), rg(10), 2'd0, 32'h55, 1'b1, rf[1], 32'h55, 1'b1, st);
        issue(rg(10), rg(3), 6'd0, 2'd0, 32'h0, 1'b0, 32'hABCD_0010, rf[3], 1'b1, st);
        check_eq("lat0_stalls", 64'(st), 64'd0);
        x_valid = 1'b1; x_wbr = rg(10); x_res = 32'hABCD_0010;
        tick();
        clr_byp();

        // load r5 then addu r6,r5,r1
        issue(rg(1), 6'd0, rg(5), 2'd1, 32'h0, 1'b1, rf[1], 32'h0, 1'b1, st);
        issue(rg(5), rg(1), rg(6), 2'd0, 32'h0, 1'b0, 32'h1234_5678, rf[1], 1'b1, st);
        check_eq("load_stalls", 64'(st), 64'd1);
        m_valid = 1'b1; m_wbr = rg(5); m_res = 32'h1234_5678;
        tick();
        clr_byp();

        // lat=3 producer r7, dependent consumer
`ifdef SCOREBOARD_PERF_EN
        ps0 = perf_stall_cycles;
        pi0 = perf_issued;
`endif
        issue(rg(2), 6'd0, rg(7), 2'd3, 32'h7, 1'b1, rf[2], 32'h7, 1'b1, st);
        issue(rg(7), rg(2), 6'd0, 2'd0, 32'h0, 1'b0, 32'hDEAD_0007, rf[2], 1'b1, st);
        check_eq("lat3_stalls", 64'(st), 64'd3);
        x_valid = 1'b1; x_wbr = rg(7); x_res = 32'hDEAD_0007;
`ifdef SCOREBOARD_PERF_EN
        check_eq("perf_stall_delta", 64'(perf_stall_cycles - ps0), 64'd3);
        check_eq("perf_issued_delta", 64'(perf_issued - pi0), 64'd2);
`endif
        tick();
        clr_byp();

        // read-during-write of r9 resolved by w2
        w_valid = 1'b1; w_wbr = rg(9); w_res = 32'hCAFE_BABE;
        issue(rg(9), rg(4), 6'd0, 2'd0, 32'h0, 1'b0, 32'hCAFE_BABE, rf[4], 1'b1, st);
        clr_byp();
        rf[9] = 32'hCAFE_BABE;
        tick();

        // bypass priority chain on r3: x, m, w, w2, regfile
        issue(rg(3), rg(3), 6'd0, 2'd0, 32'h0, 1'b0, 32'hAAAA_0003, 32'hAAAA_0003, 1'b1, st);
        x_valid = 1'b1; x_wbr = rg(3); x_res = 32'hAAAA_0003;
        m_valid = 1'b1; m_wbr = rg(3); m_res = 32'hBBBB_0003;
        w_valid = 1'b1; w_wbr = rg(3); w_res = 32'hCCCC_0003;
        issue(rg(3), rg(3), 6'd0, 2'd0, 32'h0, 1'b0, 32'hBBBB_0003, 32'hBBBB_0003, 1'b1, st);
        clr_byp();
        m_valid = 1'b1; m_wbr = rg(3); m_res = 32'hBBBB_0003;
        issue(rg(3), rg(3), 6'd0, 2'd0, 32'h0, 1'b0, 32'hDDDD_0003, 32'hDDDD_0003, 1'b1, st);
        clr_byp();
        w_valid = 1'b1; w_wbr = rg(3); w_res = 32'hDDDD_0003;
        issue(rg(3), rg(3), 6'd0, 2'd0, 32'h0, 1'b0, 32'hDDDD_0003, 32'hDDDD_0003, 1'b1, st);
        clr_byp();
        issue(rg(3), rg(3), 6'd0, 2'd0, 32'h0, 1'b0, 32'hDDDD_0003, 32'hDDDD_0003, 1'b1, st);
        clr_byp();
        rf[3] = 32'hDDDD_0003;
        tick();

        // r0 reads are zero and never stall; writes to r0 or with MSB=0 are ignored
        w_valid = 1'b1; w_wbr = 6'b10_0000; w_res = 32'hFFFF_FFFF;
        issue(rg(0), rg(0), 6'd0, 2'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, st);
        check_eq("r0_stalls", 64'(st), 64'd0);
        w_valid = 1'b1; w_wbr = {1'b0, 5'd11}; w_res = 32'hBAD0_BAD0;
        issue(rg(11), rg(0), 6'd0, 2'd0, 32'h0, 1'b0, rf[11], 32'h0, 1'b1, st);
        clr_byp();
        issue(rg(11), rg(0), 6'd0, 2'd0, 32'h0, 1'b0, rf[11], 32'h0, 1'b1, st);
        tick();

        // WAW ordering on r4
        issue(6'd0, 6'd0, rg(4), 2'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, st);
        issue(6'd0, 6'd0, rg(4), 2'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, st);
        check_eq("waw_3_then_0", 64'(st), 64'd3);
        issue(6'd0, 6'd0, rg(4), 2'd1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, st);
        check_eq("waw_0_then_1", 64'(st), 64'd0);
        issue(6'd0, 6'd0, rg(4), 2'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, st);
        check_eq("waw_1_then_3", 64'(st), 64'd0);
        for (int i = 0; i < 4; i++) tick();

        // flushed producer is dropped but its busy entry still drains
        flush_D = 1'b1;
        issue(6'd0, 6'd0, rg(12), 2'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, st);
        flush_D = 1'b0;
        check_eq("flush_d_valid", 64'(d_valid), 64'd0);
        issue(rg(12), 6'd0, 6'd0, 2'd0, 32'h0, 1'b0, rf[12], 32'h0, 1'b1, st);
        check_eq("flush_busy_stalls", 64'(st), 64'd2);
        tick();

        // reset in the middle of a stall
        issue(6'd0, 6'd0, rg(13), 2'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, st);
        i_valid = 1'b1;
        i_rs    = rg(13);
        i_rt    = 6'd0;
        i_wbr   = 6'd0;
        i_lat   = 2'd0;
        #1;
        check_eq("pre_rst_ready", 64'(i_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_d_valid", 64'(d_valid), 64'd0);
        check_eq("mid_rst_d_stall", 64'(d_stall), 64'd0);
        check_eq("mid_rst_ready", 64'(i_ready), 64'd1);
        i_valid = 1'b0;

        for (int i = 0; i < 4; i++) tick();
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stage_d_scoreboard.md
Name: stage_D_scoreboard

Overview:
- Parametrised decode/operand-read stage: a 2-read/1-write register file, a prioritised bypass network, and a per-register latency scoreboard.
- The scoreboard replaces single-load-only restart with stall/accept handshaking for producers of any latency up to MAX_LAT (loads, multi-cycle ALU ops).
- Sits between fetch and EX; the fetch side holds its instruction while i_ready is low.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count; power of two. RB = log2(NREGS).
- MAX_LAT, 3, largest producer latency class accepted; counter width CB = clog2(MAX_LAT+1).

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  instruction present.
- i_ready  out  1  combinational; instruction accepted when i_valid & i_ready.
- i_rs, i_rt  in  RB+1 each  operand specifiers; MSB=1 means operand used.
- i_wbr  in  RB+1  destination; MSB=1 means writes; r0 always encoded as 0.
- i_lat  in  CB  producer latency class (0 = ALU result on x_ next cycle).
- i_imm  in  XLEN  pre-extended immediate.
- i_op2_is_imm  in  1  op2 takes i_imm.
- flush_D  in  1  kill D-stage content.
- x_valid, x_wbr, x_res  in  1/RB+1/XLEN  EX bypass.
- m_valid, m_wbr, m_res  in  1/RB+1/XLEN  MEM bypass.
- w_valid, w_wbr, w_res  in  1/RB+1/XLEN  writeback; sole regfile write port.
- d_valid  out  1  registered.
- d_wbr  out  RB+1  registered.
- d_op1_val, d_rt_val, d_op2_val  out  XLEN  bypassed operands (combinational from registered state).
- d_stall  out  1  registered copy of ~i_ready & i_valid.

Behaviour:
- Reset: d_valid=0, d_wbr=0, d_stall=0, all busy counters=0, internal w2 bypass invalid. Regfile contents are not reset (sim init 0). Reset mid-stall drops the held instruction's stall state; fetch re-presents it.
- busy[r] (CB bits) per register, r=1..NREGS-1; busy[0] is constant 0.
- Stall condition, any of:
  - i_rs used and busy[rs]!=0.
  - i_rt used and busy[rt]!=0.
  - i_wbr writes and busy[wbr] > i_lat (WAW ordering).
  - i_lat > MAX_LAT (illegal; never accepted).
- i_ready = ~stall. An i_valid=0 cycle always has i_ready=1.
- Each cycle every nonzero busy decrements by 1.
- On accept with i_wbr writing, busy[wbr] <= i_lat. The set wins over the decrement for that entry in the same cycle.
- Latency: accept at cycle t; regfile read is synchronous, so d_* is valid at t+1.
  - lat=0 consumer may accept at t+1 and sees the x_ bypass.
  - lat=k consumer is stalled exactly k cycles.
- Bypass priority for each of op1/rt: x > m > w > w2 > regfile.
  - Match = valid & (d_reg == wbr) & wbr MSB.
  - w2 is a registered copy of w_*; it covers read-during-write, where the RAM returns the old value.
- d_op2_val = d_op2_is_imm ? d_imm : d_rt_val.
- Stall: d_valid <= 0 (bubble). Scoreboard is unchanged except for decrement.
- flush_D: d_valid <= 0 next cycle; an instruction accepted that same cycle is also dropped. Busy entries set by flushed instructions are NOT cleared; they drain naturally (conservative extra stalls only).
- Writes with w_wbr MSB=0 or index 0 are ignored.

Optional Feature:
- SCOREBOARD_PERF_EN defined:
  - Adds outputs perf_stall_cycles[31:0] (increments on i_valid & ~i_ready) and perf_issued[47:0] (increments on accept).
  - Both counters reset to 0 and wrap silently.
- Undefined: ports and counters absent. Functional behaviour is identical either way.

Decomposition:
- Package yari_decode_pkg: wbr encoding helpers (valid bit + index), latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3, and the clog2 function.
- One sub-module: regfile_2r1w (two RAM copies, synchronous read, single write).

Test Plan:
- Load r5 (lat=1) then addu r6,r5,r1 back-to-back -> i_ready=0 for exactly 1 cycle; consumer d_op1_val = m_res = 0x12345678.
- lat=3 producer r7, consumer next -> 3 stall cycles, perf_stall_cycles += 3 (with SCOREBOARD_PERF_EN); accepted on 4th cycle.
- w_ writes r9=0xCAFEBABE while i_rs=r9 is read in the same cycle -> d_op1_val=0xCAFEBABE via w2.
- x_, m_ and w_ all target r3 with distinct values -> x_res selected; writes/reads of r0 -> operand 0, no stall.
- WAW: lat=3 to r4, then lat=0 to r4 -> stall until busy[r4]==0; lat=0 then lat=3 -> no stall.
- Reset asserted while a stall is in progress -> next cycle busy all 0, d_valid=0, i_ready=1.
